// File: rtl/ogfx_if_lt24_refresh.sv
// LT24 refresh engine: streams backend pixels onto a 16-bit 8080 write bus,
// prefixed by a RAM-write command, with a one-deep prefetch buffer.
module ogfx_if_lt24_refresh #(
  parameter int          SPIX_W    = 17,
  parameter int          WR_CYCLES = 2,
  parameter logic [15:0] CMD_RAMWR = 16'h2C
) (
  input  logic              mclk,
  input  logic              puc_rst_n,
  input  logic              refresh_start_i,
  input  logic              refresh_abort_i,
  input  logic [SPIX_W-1:0] display_size_i,
  input  logic [15:0]       refresh_data_i,
  input  logic              refresh_data_ready_i,
  output logic              refresh_active_o,
  output logic              refresh_data_request_o,
  output logic              refresh_done_o,
  output logic              lcd_cs_n_o,
  output logic              lcd_rs_o,
  output logic              lcd_wr_n_o,
  output logic [15:0]       lcd_d_o
);

  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CW-1:0] WLAST = CW'(WR_CYCLES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD_LO   = 3'd1;
  localparam logic [2:0] S_CMD_HI   = 3'd2;
  localparam logic [2:0] S_PIX_WAIT = 3'd3;
  localparam logic [2:0] S_PIX_LO   = 3'd4;
  localparam logic [2:0] S_PIX_HI   = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]        state;
  logic [CW-1:0]     wcnt;
  logic [SPIX_W-1:0] size_q;
  logic [SPIX_W-1:0] req_cnt;
  logic [SPIX_W-1:0] pix_cnt;
  logic [SPIX_W-1:0] pix_nxt;
  logic              buf_vld;
  logic [15:0]       buf_d;
  logic              pend;

  logic active;
  logic phase_end;
  logic last;
  logic start_ok;
  logic abort_hit;
  logic req;
  logic load;
  logic take;

  assign active    = (state == S_CMD_LO)   || (state == S_CMD_HI) ||
                     (state == S_PIX_WAIT) || (state == S_PIX_LO) ||
                     (state == S_PIX_HI);
  assign phase_end = (wcnt == WLAST);
  assign pix_nxt   = pix_cnt + 1'b1;
  assign last      = (pix_nxt == size_q);
  assign start_ok  = (state == S_IDLE) & refresh_start_i & ~refresh_abort_i;
  assign abort_hit = refresh_abort_i & (state != S_IDLE);

  // A load always finds the buffer empty, so load/take never collide.
  assign load = refresh_data_ready_i & pend;
  assign req  = active & ~refresh_abort_i & ~buf_vld & ~pend &
                (req_cnt < size_q);
  assign take = buf_vld &
                ((state == S_PIX_WAIT) ||
                 ((state == S_PIX_HI) & phase_end & ~last));

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      size_q  <= '0;
      pix_cnt <= '0;
      lcd_d_o <= '0;
    end else if (abort_hit) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            if (display_size_i != '0) begin
              state   <= S_CMD_LO;
              size_q  <= display_size_i;
              pix_cnt <= '0;
              wcnt    <= '0;
              lcd_d_o <= CMD_RAMWR;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_CMD_LO: begin
          if (phase_end) begin
            state <= S_CMD_HI;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_CMD_HI: begin
          if (phase_end) begin
            state <= S_PIX_WAIT;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_PIX_WAIT: begin
          if (buf_vld) begin
            state   <= S_PIX_LO;
            lcd_d_o <= buf_d;
            wcnt    <= '0;
          end
        end
        S_PIX_LO: begin
          if (phase_end) begin
            state <= S_PIX_HI;
            wcnt  <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_PIX_HI: begin
          if (phase_end) begin
            wcnt    <= '0;
            pix_cnt <= pix_nxt;
            // Skip PIX_WAIT when the next pixel is already buffered.
            if (last) begin
              state <= S_DONE;
            end else if (buf_vld) begin
              state   <= S_PIX_LO;
              lcd_d_o <= buf_d;
            end else begin
              state <= S_PIX_WAIT;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      buf_vld <= 1'b0;
      buf_d   <= '0;
      pend    <= 1'b0;
      req_cnt <= '0;
    end else if (abort_hit) begin
      buf_vld <= 1'b0;
      pend    <= 1'b0;
    end else if (start_ok) begin
      buf_vld <= 1'b0;
      pend    <= 1'b0;
      req_cnt <= '0;
    end else begin
      if (req) begin
        pend    <= 1'b1;
        req_cnt <= req_cnt + 1'b1;
      end
      if (load) begin
        pend    <= 1'b0;
        buf_vld <= 1'b1;
        buf_d   <= refresh_data_i;
      end
      if (take) begin
        buf_vld <= 1'b0;
      end
    end
  end

  assign refresh_active_o       = active;
  assign refresh_data_request_o = req;
  assign refresh_done_o         = (state == S_DONE);
  assign lcd_cs_n_o             = ~active;
  assign lcd_rs_o               = ~((state == S_CMD_LO) ||
                                    (state == S_CMD_HI));
  assign lcd_wr_n_o             = ~((state == S_CMD_LO) ||
                                    (state == S_PIX_LO));

endmodule

// File: tb/tb_ogfx_if_lt24_refresh.sv
// Bench for ogfx_if_lt24_refresh: random backend latency, bus monitor,
// frame-level reference of the expected LCD write sequence.
module tb_ogfx_if_lt24_refresh;

  localparam int SPIX_W = 17;
  localparam int WRC    = 2;

  logic              mclk;
  logic              puc_rst_n;
  logic              refresh_start_i;
  logic              refresh_abort_i;
  logic [SPIX_W-1:0] display_size_i;
  logic [15:0]       refresh_data_i;
  logic              refresh_data_ready_i;
  logic              refresh_active_o;
  logic              refresh_data_request_o;
  logic              refresh_done_o;
  logic              lcd_cs_n_o;
  logic              lcd_rs_o;
  logic              lcd_wr_n_o;
  logic [15:0]       lcd_d_o;

  ogfx_if_lt24_refresh #(
    .SPIX_W(SPIX_W), .WR_CYCLES(WRC), .CMD_RAMWR(16'h2C)
  ) dut (
    .mclk                  (mclk),
    .puc_rst_n             (puc_rst_n),
    .refresh_start_i       (refresh_start_i),
    .refresh_abort_i       (refresh_abort_i),
    .display_size_i        (display_size_i),
    .refresh_data_i        (refresh_data_i),
    .refresh_data_ready_i  (refresh_data_ready_i),
    .refresh_active_o      (refresh_active_o),
    .refresh_data_request_o(refresh_data_request_o),
    .refresh_done_o        (refresh_done_o),
    .lcd_cs_n_o            (lcd_cs_n_o),
    .lcd_rs_o              (lcd_rs_o),
    .lcd_wr_n_o            (lcd_wr_n_o),
    .lcd_d_o               (lcd_d_o)
  );

  int errors = 0;
  int checks = 0;

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Bus monitor: one record per completed write strobe.
  int          cyc = 0;
  int          dones = 0;
  int          cslow = 0;
  logic        prev_wr = 1'b1;
  int          cur_fall = 0;
  logic [15:0] cur_d = '0;
  logic        cur_rs = 1'b0;
  logic        cur_ok = 1'b0;
  logic [15:0] wd_q[$];
  logic        wrs_q[$];
  logic        ok_q[$];
  int          fall_q[$];
  int          rise_q[$];

  initial begin
    forever begin
      @(negedge mclk);
      cyc++;
      if (refresh_done_o === 1'b1) dones++;
      if (lcd_cs_n_o === 1'b0) cslow++;
      if (lcd_wr_n_o === 1'b0) begin
        if (prev_wr) begin
          cur_fall = cyc;
          cur_d    = lcd_d_o;
          cur_rs   = lcd_rs_o;
          cur_ok   = (lcd_cs_n_o === 1'b0);
        end else if (lcd_d_o !== cur_d || lcd_rs_o !== cur_rs ||
                     lcd_cs_n_o !== 1'b0) begin
          cur_ok = 1'b0;
        end
      end else if (!prev_wr) begin
        wd_q.push_back(cur_d);
        wrs_q.push_back(cur_rs);
        ok_q.push_back(cur_ok);
        fall_q.push_back(cur_fall);
        rise_q.push_back(cyc);
      end
      prev_wr = (lcd_wr_n_o !== 1'b0);
    end
  end

  // Backend model: answers each request after be_delay cycles.
  logic [15:0] pix [0:255];
  int          reqs = 0;
  int          be_idx = 0;
  int          be_delay = 1;
  int          be_wait = 0;
  logic        be_pend = 1'b0;
  int          spur_req = 0;
  int          spur_done = 0;

  initial begin
    refresh_data_i       = '0;
    refresh_data_ready_i = 1'b0;
    forever begin
      @(posedge mclk);
      #1;
      refresh_data_ready_i = 1'b0;
      if (spur_req != spur_done) begin
        refresh_data_ready_i = 1'b1;
        refresh_data_i       = 16'hDEAD;
        spur_done++;
      end else if (be_pend) begin
        if (be_wait <= 1) begin
          refresh_data_ready_i = 1'b1;
          refresh_data_i       = pix[8'(be_idx)];
          be_idx++;
          be_pend = 1'b0;
        end else begin
          be_wait--;
        end
      end
      @(negedge mclk);
      if (refresh_data_request_o === 1'b1) begin
        reqs++;
        be_pend = 1'b1;
        be_wait = be_delay;
      end
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset();
    puc_rst_n       = 1'b0;
    refresh_start_i = 1'b0;
    refresh_abort_i = 1'b0;
    display_size_i  = '0;
    #23;
    checks++;
    if ({refresh_active_o, refresh_data_request_o, refresh_done_o,
         lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_d_o} !==
        {6'b000111, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got act=%b req=%b done=%b cs_n=%b rs=%b wr_n=%b d=%h",
               refresh_active_o, refresh_data_request_o, refresh_done_o,
               lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_d_o);
    end
    @(negedge mclk);
    puc_rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_frame(input int size, input int delay,
                            input bit fixed, input bit restart,
                            input string name);
    int w0, r0, d0, b0, n, k;
    be_delay = delay;
    b0 = be_idx;
    for (int i = 0; i < size; i++)
      pix[8'(b0 + i)] = fixed ? 16'((i + 1) * 16'h1111)
                              : 16'($urandom);
    w0 = wd_q.size();
    r0 = reqs;
    d0 = dones;
    tick();
    refresh_start_i = 1'b1;
    display_size_i  = SPIX_W'(size);
    tick();
    refresh_start_i = 1'b0;
    @(negedge mclk);
    checks++;
    if (refresh_active_o !== 1'b1) begin
      errors++;
      $display("FAIL %s active_rise: got %b want 1", name, refresh_active_o);
    end
    k = 0;
    while (dones == d0 && k < size * 40 + 200) begin
      tick();
      if (restart) begin
        refresh_start_i = (k == 8 || k == 20) && refresh_active_o;
        display_size_i  = SPIX_W'($urandom_range(1, 50));
      end
      k++;
    end
    refresh_start_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (dones == d0) begin
      errors++;
      $display("FAIL %s timeout: got no done after %0d cycles want done", name, k);
    end
    n = wd_q.size() - w0;
    checks++;
    if (n != size + 1) begin
      errors++;
      $display("FAIL %s write_count: got %0d want %0d", name, n, size + 1);
    end
    for (int i = 0; i < n && i <= size; i++) begin
      logic [15:0] ed;
      logic        er;
      ed = (i == 0) ? 16'h002C : pix[8'(b0 + i - 1)];
      er = (i != 0);
      checks++;
      if (wd_q[w0 + i] !== ed || wrs_q[w0 + i] !== er ||
          ok_q[w0 + i] !== 1'b1) begin
        errors++;
        $display("FAIL %s write%0d: got rs=%b d=%h stable=%b want rs=%b d=%h stable=1",
                 name, i, wrs_q[w0 + i], wd_q[w0 + i], ok_q[w0 + i], er, ed);
      end
      checks++;
      if (rise_q[w0 + i] - fall_q[w0 + i] != WRC ||
          (i > 0 && fall_q[w0 + i] - rise_q[w0 + i - 1] < WRC)) begin
        errors++;
        $display("FAIL %s strobe%0d: got low=%0d high=%0d want low=%0d high>=%0d",
                 name, i, rise_q[w0 + i] - fall_q[w0 + i],
                 (i > 0) ? fall_q[w0 + i] - rise_q[w0 + i - 1] : WRC,
                 WRC, WRC);
      end
    end
    checks++;
    if (reqs - r0 != size || dones - d0 != 1 || refresh_active_o !== 1'b0) begin
      errors++;
      $display("FAIL %s counts: got reqs=%0d dones=%0d act=%b want reqs=%0d dones=1 act=0",
               name, reqs - r0, dones - d0, refresh_active_o, size);
    end
  endtask

  task automatic test_size_zero();
    int w0, r0, d0, c0;
    w0 = wd_q.size();
    r0 = reqs;
    d0 = dones;
    c0 = cslow;
    tick();
    refresh_start_i = 1'b1;
    display_size_i  = '0;
    tick();
    refresh_start_i = 1'b0;
    @(negedge mclk);
    checks++;
    if (refresh_done_o !== 1'b1 || refresh_active_o !== 1'b0) begin
      errors++;
      $display("FAIL size0_done: got done=%b act=%b want done=1 act=0",
               refresh_done_o, refresh_active_o);
    end
    repeat (5) tick();
    checks++;
    if (wd_q.size() != w0 || reqs != r0 || cslow != c0 || dones - d0 != 1) begin
      errors++;
      $display("FAIL size0_quiet: got writes=%0d reqs=%0d cs_low=%0d dones=%0d want 0 0 0 1",
               wd_q.size() - w0, reqs - r0, cslow - c0, dones - d0);
    end
  endtask

  task automatic test_abort();
    int w0, d0, ra, wa, k;
    be_delay = 1;
    for (int i = 0; i < 6; i++) pix[8'(be_idx + i)] = 16'($urandom);
    w0 = wd_q.size();
    d0 = dones;
    tick();
    refresh_start_i = 1'b1;
    display_size_i  = SPIX_W'(6);
    tick();
    refresh_start_i = 1'b0;
    k = 0;
    while (wd_q.size() - w0 < 3 && k < 200) begin
      @(negedge mclk);
      k++;
    end
    checks++;
    if (wd_q.size() - w0 < 3) begin
      errors++;
      $display("FAIL abort_setup: got %0d writes want 3", wd_q.size() - w0);
    end
    tick();
    refresh_abort_i = 1'b1;
    tick();
    refresh_abort_i = 1'b0;
    @(negedge mclk);
    checks++;
    if ({refresh_active_o, lcd_cs_n_o, lcd_wr_n_o, refresh_done_o} !== 4'b0110) begin
      errors++;
      $display("FAIL abort_idle: got act=%b cs_n=%b wr_n=%b done=%b want 0 1 1 0",
               refresh_active_o, lcd_cs_n_o, lcd_wr_n_o, refresh_done_o);
    end
    ra = reqs;
    tick();
    wa = wd_q.size();
    spur_req++;
    repeat (20) tick();
    checks++;
    if (dones != d0 || wd_q.size() != wa || reqs != ra ||
        refresh_active_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got dones=%0d writes=%0d reqs=%0d act=%b want 0 0 0 0",
               dones - d0, wd_q.size() - wa, reqs - ra, refresh_active_o);
    end
  endtask

  task automatic test_reset_mid();
    int w0, k;
    be_delay = 1;
    for (int i = 0; i < 5; i++) pix[8'(be_idx + i)] = 16'($urandom);
    w0 = wd_q.size();
    tick();
    refresh_start_i = 1'b1;
    display_size_i  = SPIX_W'(5);
    tick();
    refresh_start_i = 1'b0;
    k = 0;
    do begin
      @(negedge mclk);
      k++;
    end while (!(wd_q.size() - w0 >= 2 && lcd_wr_n_o === 1'b0 &&
                 lcd_rs_o === 1'b1) && k < 200);
    #2;
    puc_rst_n = 1'b0;
    #1;
    checks++;
    if ({refresh_active_o, refresh_data_request_o, refresh_done_o,
         lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_d_o} !==
        {6'b000111, 16'h0000} || k >= 200) begin
      errors++;
      $display("FAIL reset_mid: got act=%b cs_n=%b rs=%b wr_n=%b d=%h waited=%0d want 0 1 1 1 0000",
               refresh_active_o, lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o,
               lcd_d_o, k);
    end
    repeat (2) @(negedge mclk);
    puc_rst_n = 1'b1;
    repeat (10) tick();
    test_frame(4, 1, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_frame(4, 1, 1'b1, 1'b0, "basic4");
    test_frame(3, 10, 1'b0, 1'b0, "slow3");
    test_size_zero();
    test_abort();
    test_frame(5, 1, 1'b0, 1'b0, "post_abort");
    test_frame(6, 2, 1'b0, 1'b1, "restart_ignored");
    for (int r = 0; r < 4; r++)
      test_frame(int'($urandom_range(1, 8)), int'($urandom_range(1, 4)),
                 1'b0, 1'b0, "random");
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
